// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the pipeline's data port.
// Serves byte/half/word loads and stores from an internal word-organised RAM
// after WAIT_CYCLES wait states, pulsing ack_o for one cycle on completion.
//
// Optional build macro DMEM_MISALIGN_CHECK_EN:
//   defined   -> misaligned half/word requests complete with err_o=1,
//                rdata_o=0 and no RAM write.
//   undefined -> err_o is 0 and the effective address is forced aligned.
//
// Handshake: req_valid_i is held high by the pipeline until the edge that
// ends the ack_o cycle; a request is accepted only in IDLE, and only the
// latched copy is executed. stall_o = req_valid_i & ~ack_o.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t state;
  state_t state_next;

  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [3:0]  lat_we;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_f3;

  // The request being worked on: live inputs while IDLE (the zero-wait
  // commit happens on the acceptance edge itself), latched copy afterwards.
  logic [31:0] cur_addr;
  logic [3:0]  cur_we;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_f3;

  logic        enter_resp;
  logic        is_store;
  logic        size_half;
  logic        size_word;
  logic        misalign;
  logic        err_hit;
  logic [1:0]  eff_off;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]  wr_lanes;
  logic [31:0] wr_data;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        do_write;

  logic [31:0] mem [2**ADDR_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^cur_addr[31:ADDR_W+2];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req_valid_i) state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd1) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: ack for the single RESP cycle, stall while a request waits.
  always_comb begin
    ack_o   = (state == S_RESP);
    stall_o = req_valid_i & ~ack_o;
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      lat_addr  <= 32'd0;
      lat_we    <= 4'd0;
      lat_wdata <= 32'd0;
      lat_f3    <= 3'd0;
    end else if (state == S_IDLE && req_valid_i) begin
      cnt       <= WAIT_LD;
      lat_addr  <= addr_i;
      lat_we    <= we_i;
      lat_wdata <= wdata_i;
      lat_f3    <= funct3_i;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Select the live or latched request and derive size / alignment.
  always_comb begin
    if (state == S_IDLE) begin
      cur_addr  = addr_i;
      cur_we    = we_i;
      cur_wdata = wdata_i;
      cur_f3    = funct3_i;
    end else begin
      cur_addr  = lat_addr;
      cur_we    = lat_we;
      cur_wdata = lat_wdata;
      cur_f3    = lat_f3;
    end
    enter_resp = (state_next == S_RESP) && (state != S_RESP);
    is_store   = |cur_we;
    if (is_store) begin
      size_word = cur_we[3];
      size_half = ~cur_we[3] & cur_we[1];
    end else begin
      size_word = cur_f3[1];
      size_half = (cur_f3[1:0] == 2'b01);
    end
    misalign = (size_half & cur_addr[0]) | (size_word & (|cur_addr[1:0]));
`ifdef DMEM_MISALIGN_CHECK_EN
    err_hit = misalign;
    eff_off = cur_addr[1:0];
`else
    err_hit = 1'b0;
    if (size_word)      eff_off = 2'b00;
    else if (size_half) eff_off = {cur_addr[1], 1'b0};
    else                eff_off = cur_addr[1:0];
`endif
    word_idx = cur_addr[ADDR_W+1:2];
    wr_lanes = cur_we << eff_off;
    wr_data  = cur_wdata << {eff_off, 3'b000};
    do_write = rst_n & enter_resp & is_store & ~err_hit;
  end

  // Load extraction and extension.
  always_comb begin
    rd_word  = mem[word_idx];
    shifted  = rd_word >> {eff_off, 3'b000};
    load_val = shifted;
    case (cur_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // RAM byte-lane write at the RESP-entry edge; reset suppresses it.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Response data and error flag, captured at the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else if (enter_resp) begin
      err_o   <= err_hit;
      rdata_o <= (is_store | err_hit) ? 32'd0 : load_val;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with zero wait states
// (index 0) and one with three wait states (index 1), each with its own
// request bus and reset.
module tb_data_mem_responder;

  localparam int ADDR_W = 10;

  logic        clk;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic [31:0] addr      [2];
  logic [3:0]  we        [2];
  logic [31:0] wdata     [2];
  logic [2:0]  funct3    [2];
  logic [31:0] rdata     [2];
  logic        ack       [2];
  logic        stall     [2];
  logic        err       [2];

  int tests_run;
  int tests_failed;

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid_i(req_valid[0]), .addr_i(addr[0]),
    .we_i(we[0]), .wdata_i(wdata[0]), .funct3_i(funct3[0]), .rdata_o(rdata[0]),
    .ack_o(ack[0]), .stall_o(stall[0]), .err_o(err[0])
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid_i(req_valid[1]), .addr_i(addr[1]),
    .we_i(we[1]), .wdata_i(wdata[1]), .funct3_i(funct3[1]), .rdata_o(rdata[1]),
    .ack_o(ack[1]), .stall_o(stall[1]), .err_o(err[1])
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request and wait (bounded) for its ack. If chg_n is nonzero,
  // addr/wdata are altered chg_n cycles after the acceptance cycle.
  task automatic do_req(input int d, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] wd, input logic [2:0] f3, input int chg_n,
                        input logic [31:0] chg_a, input logic [31:0] chg_wd,
                        output logic [31:0] rd, output logic er);
    int n;
    int stall_cnt;
    int exp_lat;
    logic got;
    exp_lat = (d == 0) ? 1 : 4;
    @(negedge clk);
    addr[d] = a; we[d] = w; wdata[d] = wd; funct3[d] = f3; req_valid[d] = 1'b1;
    #1;
    stall_cnt = stall[d] ? 1 : 0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack[d]) got = 1'b1;
      else begin
        if (stall[d]) stall_cnt++;
        if (n == chg_n) begin addr[d] = chg_a; wdata[d] = chg_wd; end
      end
    end
    check("ack_seen", {31'd0, got}, 32'd1);
    check("latency", 32'(n), 32'(exp_lat));
    check("stall_cycles", 32'(stall_cnt), 32'(exp_lat));
    check("stall_in_resp", {31'd0, stall[d]}, 32'd0);
    rd = rdata[d];
    er = err[d];
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    check("ack_pulse", {31'd0, ack[d]}, 32'd0);
  endtask

  task automatic st(input int d, input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd);
    logic [31:0] rd;
    logic er;
    do_req(d, a, w, wd, 3'b010, 0, 32'd0, 32'd0, rd, er);
    check("store_rdata", rd, 32'd0);
    check("store_err", {31'd0, er}, 32'd0);
  endtask

  task automatic ld(input int d, input string tag, input logic [31:0] a,
                    input logic [2:0] f3, input logic [31:0] exp);
    logic [31:0] rd;
    logic er;
    do_req(d, a, 4'b0000, 32'hFFFF_FFFF, f3, 0, 32'd0, 32'd0, rd, er);
    check(tag, rd, exp);
    check("load_err", {31'd0, er}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int ack_hits;
    tests_run = 0;
    tests_failed = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; addr[d] = '0;
      we[d] = '0; wdata[d] = '0; funct3[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ack", {31'd0, ack[d]}, 32'd0);
      check("rst_rdata", rdata[d], 32'd0);
      check("rst_err", {31'd0, err[d]}, 32'd0);
      check("rst_stall", {31'd0, stall[d]}, 32'd0);
    end

    // Zero wait states: word, byte and halfword traffic.
    st(0, 32'h10, 4'b1111, 32'hDEAD_BEEF);
    ld(0, "lw_10", 32'h10, 3'b010, 32'hDEAD_BEEF);
    st(0, 32'h13, 4'b0001, 32'h0000_00AA);
    ld(0, "lw_after_sb", 32'h10, 3'b010, 32'hAAAD_BEEF);
    ld(0, "lb_13", 32'h13, 3'b000, 32'hFFFF_FFAA);
    ld(0, "lbu_13", 32'h13, 3'b100, 32'h0000_00AA);
    st(0, 32'h12, 4'b0011, 32'h0000_8001);
    ld(0, "lh_12", 32'h12, 3'b001, 32'hFFFF_8001);
    ld(0, "lhu_12", 32'h12, 3'b101, 32'h0000_8001);
    ld(0, "lw_after_sh", 32'h10, 3'b010, 32'h8001_BEEF);
    ld(0, "lb_11", 32'h11, 3'b000, 32'hFFFF_FFBE);
    ld(0, "funct3_111", 32'h10, 3'b111, 32'h8001_BEEF);

    // Three wait states: inputs changed mid-request must not matter.
    st(1, 32'h34, 4'b1111, 32'h0000_0000);
    do_req(1, 32'h30, 4'b1111, 32'h1111_1111, 3'b010, 2, 32'h34, 32'h2222_2222, rd, er);
    check("chg_store_rdata", rd, 32'd0);
    ld(1, "lw_30_orig", 32'h30, 3'b010, 32'h1111_1111);
    ld(1, "lw_34_untouched", 32'h34, 3'b010, 32'h0000_0000);

    // Reset during WAIT drops the store and never acks.
    st(1, 32'h20, 4'b1111, 32'hAAAA_5555);
    @(negedge clk);
    addr[1] = 32'h20; we[1] = 4'b1111; wdata[1] = 32'h1234_5678; req_valid[1] = 1'b1;
    ack_hits = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[1]) ack_hits++;
    end
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    req_valid[1] = 1'b0;
    repeat (6) begin
      if (ack[1]) ack_hits++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_ack", 32'(ack_hits), 32'd0);
    ld(1, "lw_20_after_rst", 32'h20, 3'b010, 32'hAAAA_5555);

    // Aliasing modulo RAM size.
    st(1, 32'h20 + 4 * (2 ** ADDR_W), 4'b1111, 32'h0BAD_F00D);
    ld(1, "lw_20_alias", 32'h20, 3'b010, 32'h0BAD_F00D);

    // Misaligned word store.
    do_req(0, 32'h11, 4'b1111, 32'hCAFE_F00D, 3'b010, 0, 32'd0, 32'd0, rd, er);
    check("mis_rdata", rd, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("mis_err", {31'd0, er}, 32'd1);
    ld(0, "mis_lw_10", 32'h10, 3'b010, 32'h8001_BEEF);
`else
    check("mis_err", {31'd0, er}, 32'd0);
    ld(0, "mis_lw_10", 32'h10, 3'b010, 32'hCAFE_F00D);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port.
- Accepts load/store requests from the MEM stage: address, write data, and a low-aligned byte-lane mask (0001 sb, 0011 sh, 1111 sw, 0000 load).
- Serves each request from an internal word-organised RAM after a configurable number of wait states, then acknowledges.
- Raises a stall while a request is outstanding, aligns store lanes and data to the address, and extracts and extends load data per funct3.

Parameters:
- ADDR_W, 10: word-address width; RAM holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 0: wait states between acceptance and response (0..15).

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset, synchronous, active-low.
- req_valid_i  in  1: request present; held high by the pipeline until ack_o.
- addr_i  in  32: byte address.
- we_i  in  4: low-aligned byte-lane mask; 0000 means load.
- wdata_i  in  32: store data, low-aligned.
- funct3_i  in  3: load type; 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- rdata_o  out  32: extended load data; valid while ack_o=1.
- ack_o  out  1: one-cycle completion pulse.
- stall_o  out  1: pipeline hold request.
- err_o  out  1: misaligned access flag, valid with ack_o.

Behaviour:
- Reset: state IDLE; ack_o=0, rdata_o=0, err_o=0, wait counter=0, latched request cleared. RAM contents are not reset.
- FSM states IDLE, WAIT, RESP.
  - IDLE: if req_valid_i=1, latch addr, we, wdata and funct3, load counter with WAIT_CYCLES. Go to RESP if WAIT_CYCLES=0, else WAIT.
  - WAIT: decrement counter each cycle; on the edge where counter=1, go to RESP.
  - RESP: ack_o=1 for exactly one cycle, then always IDLE. The pipeline advances on the ack edge; the next request is accepted no earlier than the following cycle.
- Latency: ack_o asserted WAIT_CYCLES+1 cycles after the acceptance edge.
- Inputs are ignored outside IDLE; the latched request is the one executed.
- stall_o = req_valid_i & ~ack_o, combinational. It is high during the acceptance cycle and all WAIT cycles, and low in the RESP cycle.
- Commit point: store write and load read both occur on the edge entering RESP.
  - Write lanes = latched we << addr[1:0], truncated to 4 bits.
  - Write data = latched wdata << 8*addr[1:0].
  - Only enabled byte lanes change.
- Load path:
  - word = RAM[addr[ADDR_W+1:2]]; shifted = word >> 8*addr[1:0].
  - LB/LH: sign-extend bit 7/15 of shifted.
  - LBU/LHU: zero-extend.
  - LW, and unsupported funct3 011/110/111: full shifted value.
  - rdata_o is registered and held until the next RESP; it is 0 for stores.
- Address: upper bits above ADDR_W+1 are ignored; accesses wrap and alias modulo RAM size.
- Reset mid-operation (WAIT): request dropped, no memory write, no ack, state IDLE.
- Reset asserted in the same cycle as the RESP-entry edge: reset wins, no write, no ack.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: a request is misaligned if it is a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - A misaligned request still runs the full FSM timing.
  - At RESP: err_o=1, rdata_o=0, no RAM write.
  - Aligned requests give err_o=0.
- Undefined: err_o tied 0. Effective address is forced aligned:
  - halfword: addr[0] treated as 0;
  - word: addr[1:0] treated as 00.
  - The access then proceeds normally.

Test Plan:
- WAIT_CYCLES=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> each acked 1 cycle after acceptance; lw rdata_o=0xDEADBEEF; stall_o high exactly 1 cycle per request.
- After the previous test: sb wdata 0x000000AA @0x13 -> lw @0x10 returns 0xAAADBEEF; lb @0x13 returns 0xFFFFFFAA; lbu @0x13 returns 0x000000AA.
- sh 0x00008001 @0x12 -> lh @0x12 returns 0xFFFF8001; lhu @0x12 returns 0x00008001; lw @0x10 returns 0x8001BEEF.
- WAIT_CYCLES=3: request accepted at cycle t -> ack_o only at t+4, stall_o high t..t+3. addr_i/wdata_i changed at t+2 are ignored; the original store lands.
- WAIT_CYCLES=3: sw 0x12345678 @0x20, rst_n low for one cycle at t+2 -> no ack; later lw @0x20 returns the old contents. sw @0x20+4*2**ADDR_W aliases to 0x20.
- sw 0xCAFEF00D @0x11:
  - with DMEM_MISALIGN_CHECK_EN -> err_o=1 on ack, word @0x10 unchanged.
  - without the macro -> err_o=0, lw @0x10 returns 0xCAFEF00D.
